// File: rtl/text_buf_writer_if.sv
// Character-stream input and character-buffer write port of the text buffer writer.
// The master side drives characters; the slave side is the writer itself.
interface text_buf_writer_if #(
  parameter int AW = 12
);
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [6:0]    cursor_col;
  logic [4:0]    cursor_row;
  logic          busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy
  );
endinterface

// File: rtl/text_buf_writer.sv
// Turns an ASCII character stream into character-buffer writes with a tracked cursor,
// including a full-screen clear after reset and on form feed.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | accepting characters, one per cycle
// S_CLEAR | writing a space to every buffer cell, input stalled
module text_buf_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int AW   = 12
) (
  input  logic              clk,
  input  logic              rst,
  text_buf_writer_if.slave  bus
);
  localparam int           TOTAL    = COLS * ROWS;
  localparam logic [6:0]   LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]   LAST_ROW = 5'(ROWS - 1);
  localparam logic [AW:0]  CLR_END  = (AW+1)'(TOTAL);
  localparam logic [AW:0]  CNT_ONE  = (AW+1)'(1);
  localparam logic [7:0]   SPACE    = 8'h20;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t        r_state;
  logic          r_in_ready;
  logic          r_busy;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_wr_data;
  logic [6:0]    r_col;
  logic [4:0]    r_row;
  logic [AW:0]   r_clr_cnt;

  logic          w_accept;
  logic [AW-1:0] w_cur_addr;
  logic [AW-1:0] w_bs_addr;
  logic [4:0]    w_next_row;

  assign w_accept   = r_in_ready & bus.in_valid;
  // Address math done in 32 bits so row*COLS never truncates before the final cast.
  assign w_cur_addr = AW'(32'(r_row) * 32'(COLS) + 32'(r_col));
  assign w_bs_addr  = AW'(32'(r_row) * 32'(COLS) + 32'(r_col) - 32'd1);
  assign w_next_row = (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_CLEAR;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b1;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= SPACE;
      r_col      <= 7'd0;
      r_row      <= 5'd0;
      r_clr_cnt  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          // The counter runs one past the last cell so the final write still shows busy.
          if (r_clr_cnt == CLR_END) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_clr_cnt[AW-1:0];
            r_wr_data <= SPACE;
            r_clr_cnt <= r_clr_cnt + CNT_ONE;
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            if (bus.in_data inside {[8'h20:8'h7E]}) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= w_cur_addr;
              r_wr_data <= bus.in_data;
              if (r_col == LAST_COL) begin
                r_col <= 7'd0;
                r_row <= w_next_row;
              end else begin
                r_col <= r_col + 7'd1;
              end
            end else begin
              case (bus.in_data)
                8'h0A: r_row <= w_next_row;
                8'h0D: r_col <= 7'd0;
                8'h08: begin
                  if (r_col != 7'd0) begin
                    r_col     <= r_col - 7'd1;
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= w_bs_addr;
                    r_wr_data <= SPACE;
                  end
                end
                8'h0C: begin
                  r_col      <= 7'd0;
                  r_row      <= 5'd0;
                  r_state    <= S_CLEAR;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_clr_cnt  <= '0;
                end
                default: ;
              endcase
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.busy       = r_busy;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.cursor_col = r_col;
  assign bus.cursor_row = r_row;
endmodule

// File: tb/tb_text_buf_writer.sv
// Bench for text_buf_writer: screen-level reference model checked every cycle,
// plus directed character sequences with hand-computed expectations.
module tb_text_buf_writer;
  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int AW    = 12;
  localparam int TOTAL = COLS * ROWS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  text_buf_writer_if #(.AW(AW)) bus ();

  text_buf_writer #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  // Screen-level model: cursor kept as (col,row), printable advance done on the linear position.
  bit m_on = 1'b0;
  int m_wr_en, m_addr, m_data, m_col, m_row, m_ready, m_clr;

  initial begin
    int c, p;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_on = 1'b1; m_wr_en = 0; m_addr = 0; m_data = 32; m_col = 0; m_row = 0;
        m_ready = 0; m_clr = 0;
      end else if (m_on) begin
        m_wr_en = 0;
        if (m_ready == 0) begin
          if (m_clr < TOTAL) begin
            m_wr_en = 1; m_addr = m_clr; m_data = 32; m_clr++;
          end else begin
            m_ready = 1;
          end
        end else if (bus.in_valid) begin
          c = int'(bus.in_data);
          p = m_row * COLS + m_col;
          if (c >= 32 && c <= 126) begin
            m_wr_en = 1; m_addr = p; m_data = c;
            p = (p + 1) % TOTAL;
            m_col = p % COLS; m_row = p / COLS;
          end else if (c == 10) begin
            m_row = (m_row + 1) % ROWS;
          end else if (c == 13) begin
            m_col = 0;
          end else if (c == 8) begin
            if (m_col > 0) begin
              m_col--; m_wr_en = 1; m_addr = m_row * COLS + m_col; m_data = 32;
            end
          end else if (c == 12) begin
            m_col = 0; m_row = 0; m_ready = 0; m_clr = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_on) begin
        chk("cyc_wr_en",    int'(bus.wr_en),      m_wr_en);
        chk("cyc_wr_addr",  int'(bus.wr_addr),    m_addr);
        chk("cyc_wr_data",  int'(bus.wr_data),    m_data);
        chk("cyc_col",      int'(bus.cursor_col), m_col);
        chk("cyc_row",      int'(bus.cursor_row), m_row);
        chk("cyc_in_ready", int'(bus.in_ready),   m_ready);
        chk("cyc_busy",     int'(bus.busy),       1 - m_ready);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", int'(n < 5000), 1);
    @(negedge clk);
  endtask

  task automatic cursor_is(input string name, input int col, input int row);
    chk({name, "_col"}, int'(bus.cursor_col), col);
    chk({name, "_row"}, int'(bus.cursor_row), row);
  endtask

  task automatic write_is(input string name, input int addr, input int data);
    chk({name, "_wr_en"}, int'(bus.wr_en), 1);
    chk({name, "_addr"},  int'(bus.wr_addr), addr);
    chk({name, "_data"},  int'(bus.wr_data), data);
  endtask

  initial begin
    int k, nw;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_addr", int'(bus.wr_addr), 0);
    chk("rst_data", int'(bus.wr_data), 32);
    chk("rst_ready", int'(bus.in_ready), 0);
    chk("rst_busy", int'(bus.busy), 1);
    cursor_is("rst", 0, 0);

    rst = 1'b0;
    for (int i = 1; i <= TOTAL + 1; i++) begin
      @(negedge clk);
      if (i == 1) write_is("clr_first", 0, 32);
      if (i == TOTAL) begin
        write_is("clr_last", TOTAL - 1, 32);
        chk("clr_last_ready", int'(bus.in_ready), 0);
      end
      if (i == TOTAL + 1) begin
        chk("clr_done_ready", int'(bus.in_ready), 1);
        chk("clr_done_wr_en", int'(bus.wr_en), 0);
        cursor_is("clr_done", 0, 0);
      end
    end

    send(8'h48); write_is("H", 0, 8'h48); cursor_is("H", 1, 0);
    send(8'h69); write_is("i", 1, 8'h69); cursor_is("i", 2, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("hold_wr_en", int'(bus.wr_en), 0);
    chk("hold_addr", int'(bus.wr_addr), 1);
    chk("hold_data", int'(bus.wr_data), 8'h69);

    send(8'h01); chk("ctl01_wr_en", int'(bus.wr_en), 0); cursor_is("ctl01", 2, 0);
    send(8'h7F); chk("del_wr_en", int'(bus.wr_en), 0);   cursor_is("del", 2, 0);
    send(8'h0D); cursor_is("cr0", 0, 0);
    send(8'h08); chk("bs0_wr_en", int'(bus.wr_en), 0);   cursor_is("bs0", 0, 0);

    for (int i = 0; i < 29; i++) send(8'h0A);
    cursor_is("lf29", 0, 29);
    for (int i = 0; i < 79; i++) send(8'h78);
    cursor_is("x79", 79, 29);
    send(8'h41); write_is("wrapA", 2399, 8'h41); cursor_is("wrapA", 0, 0);

    for (int i = 0; i < 3; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h79);
    cursor_is("pos53", 5, 3);
    send(8'h08); write_is("bs", 244, 32);               cursor_is("bs", 4, 3);
    send(8'h0D); chk("cr_wr_en", int'(bus.wr_en), 0);   cursor_is("cr", 0, 3);
    send(8'h0A); chk("lf_wr_en", int'(bus.wr_en), 0);   cursor_is("lf", 0, 4);

    for (int i = 0; i < 6; i++) send(8'h0A);
    for (int i = 0; i < 10; i++) send(8'h7A);
    cursor_is("pos1010", 10, 10);
    send(8'h0C);
    chk("ff_ready", int'(bus.in_ready), 0);
    chk("ff_busy", int'(bus.busy), 1);
    chk("ff_wr_en", int'(bus.wr_en), 0);
    cursor_is("ff", 0, 0);
    bus.in_data = 8'h5A;
    k = 0; nw = 0;
    while (!bus.in_ready && k < 3000) begin
      @(negedge clk);
      if (bus.wr_en && !bus.in_ready) nw++;
      k++;
    end
    chk("ff_clear_timeout", int'(k < 3000), 1);
    chk("ff_clear_writes", nw, TOTAL);
    @(negedge clk);
    write_is("afterff_Z", 0, 8'h5A);
    cursor_is("afterff_Z", 1, 0);
    bus.in_valid = 1'b0;

    send(8'h0C);
    bus.in_valid = 1'b0;
    k = 0;
    while (!(bus.wr_en && bus.wr_addr == 12'd1000) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("addr1000_timeout", int'(k < 3000), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wr_en", int'(bus.wr_en), 0);
    chk("midrst_addr", int'(bus.wr_addr), 0);
    chk("midrst_busy", int'(bus.busy), 1);
    rst = 1'b0;
    @(negedge clk);
    write_is("restart", 0, 32);
    k = 0;
    while (!bus.in_ready && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("restart_timeout", int'(k < 3000), 1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
